// File: rtl/cmos_dvp_pkg.sv
// Shared types and constants for the DVP camera-side transmitter.
package cmos_dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } dvp_state_e;

  localparam int BAR_COUNT = 8;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] barColor(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame/line timing for the DVP transmitter: state FSM plus byte and line counters.
// States with zero lines are skipped; every line is 2*H_ACTIVE+H_BLANK byte clocks.
module dvp_timing_gen
  import cmos_dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACTIVE = 480,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10,
  parameter int CNT_W    = $clog2(2*H_ACTIVE + H_BLANK)
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             en,
  output dvp_state_e       state_o,
  output dvp_state_e       next_state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             line_end_o,
  output logic             frame_end_o
);

  localparam int LINE_LEN = 2*H_ACTIVE + H_BLANK;
  localparam int MAX_A    = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
  localparam int MAX_B    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LINE_W   = $clog2(MAX_LINES + 1);

  localparam dvp_state_e START_ST = (VS_LINES > 0) ? VSYNC : ((V_BACK > 0) ? VBACK : ACTIVE);
  localparam dvp_state_e END_ST   = (V_FRONT > 0) ? VFRONT : ACTIVE;

  function automatic int linesIn(input dvp_state_e s);
    case (s)
      VSYNC:   return VS_LINES;
      VBACK:   return V_BACK;
      ACTIVE:  return V_ACTIVE;
      VFRONT:  return V_FRONT;
      default: return 1;
    endcase
  endfunction

  dvp_state_e        state_q, state_d;
  logic [CNT_W-1:0]  byteCnt_q, byteCnt_d;
  logic [LINE_W-1:0] lineCnt_q, lineCnt_d;
  logic              lineEnd, lastLine, stateEnd;

  always_comb begin
    lineEnd   = (state_q != IDLE) && (byteCnt_q == CNT_W'(LINE_LEN - 1));
    lastLine  = (lineCnt_q == LINE_W'(linesIn(state_q) - 1));
    stateEnd  = lineEnd && lastLine;
    state_d   = state_q;
    byteCnt_d = byteCnt_q;
    lineCnt_d = lineCnt_q;
    if (state_q == IDLE) begin
      if (en) state_d = START_ST;
    end else begin
      byteCnt_d = lineEnd ? '0 : byteCnt_q + 1'b1;
      if (lineEnd) lineCnt_d = lastLine ? '0 : lineCnt_q + 1'b1;
      // en only matters at the very last cycle of a frame
      if (stateEnd) begin
        if (state_q == END_ST) begin
          state_d = en ? START_ST : IDLE;
        end else begin
          case (state_q)
            VSYNC:   state_d = (V_BACK > 0) ? VBACK : ACTIVE;
            VBACK:   state_d = ACTIVE;
            ACTIVE:  state_d = VFRONT;
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      byteCnt_q <= '0;
      lineCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      byteCnt_q <= byteCnt_d;
      lineCnt_q <= lineCnt_d;
    end
  end

  assign state_o      = state_q;
  assign next_state_o = state_d;
  assign cnt_o        = byteCnt_q;
  assign line_end_o   = lineEnd;
  assign frame_end_o  = stateEnd && (state_q == END_ST);

endmodule

// File: rtl/cmos_16_8bit_tx.sv
// DVP transmitter: serializes RGB565 pixels into high/low byte pairs under generated frame timing.
// Optional colour-bar test pattern is built in with CMOS_TX_COLORBAR_EN.
module cmos_16_8bit_tx
  import cmos_dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACTIVE = 480,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
`ifdef CMOS_TX_COLORBAR_EN
  input  logic        test_mode,
`endif
  output logic        pix_req,
  output logic        vs_o,
  output logic        de_o,
  output logic [7:0]  pdata_o,
  output logic        frame_done,
  output logic        underrun
);

  localparam int CNT_W = $clog2(2*H_ACTIVE + H_BLANK);
  localparam logic [CNT_W-1:0] DE_END  = CNT_W'(2*H_ACTIVE);
  localparam logic [CNT_W-1:0] LAST_LO = CNT_W'(2*H_ACTIVE - 1);

  dvp_state_e       state, nextState;
  logic [CNT_W-1:0] cnt;
  logic             lineEnd, frameEnd;
  logic             loadReq;
  logic [15:0]      pix_q, pix_d;
  logic             underrun_q;

  dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .VS_LINES (VS_LINES),
    .V_BACK   (V_BACK),
    .V_FRONT  (V_FRONT),
    .CNT_W    (CNT_W)
  ) u_timing (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .en           (en),
    .state_o      (state),
    .next_state_o (nextState),
    .cnt_o        (cnt),
    .line_end_o   (lineEnd),
    .frame_end_o  (frameEnd)
  );

  // Pixel 0 is fetched on the cycle before an active line; pixel n+1 on pixel n's low byte.
  assign loadReq = ((lineEnd || state == IDLE) && nextState == ACTIVE) ||
                   (state == ACTIVE && cnt[0] && cnt < LAST_LO);

`ifdef CMOS_TX_COLORBAR_EN
  localparam int BAR_W = (H_ACTIVE / BAR_COUNT > 0) ? H_ACTIVE / BAR_COUNT : 1;

  logic             testMode_q, tmEff;
  logic [CNT_W-1:0] pixIdx;
  int               barNum;

  always_comb begin
    tmEff   = (state == IDLE || frameEnd) ? test_mode : testMode_q;
    pixIdx  = (state == ACTIVE && cnt < DE_END) ? (cnt + 1'b1) >> 1 : '0;
    barNum  = int'(pixIdx) / BAR_W;
    if (barNum > BAR_COUNT - 1) barNum = BAR_COUNT - 1;
    pix_req = loadReq && !tmEff;
    pix_d   = tmEff ? barColor(3'(barNum)) : (pix_valid ? pix_data : 16'h0000);
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) testMode_q <= 1'b0;
    else if (state == IDLE || frameEnd) testMode_q <= test_mode;
  end
`else
  always_comb begin
    pix_req = loadReq;
    pix_d   = pix_valid ? pix_data : 16'h0000;
  end
`endif

  // Timing never stalls: a missing pixel is replaced by black and flagged.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      pix_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (loadReq) pix_q <= pix_d;
      if (pix_req && !pix_valid) underrun_q <= 1'b1;
    end
  end

  assign vs_o       = (state == VSYNC);
  assign de_o       = (state == ACTIVE) && (cnt < DE_END);
  assign pdata_o    = de_o ? (cnt[0] ? pix_q[7:0] : pix_q[15:8]) : 8'h00;
  assign frame_done = frameEnd;
  assign underrun   = underrun_q;

endmodule
